// File: rtl/alu_multicycle_if.sv
// Request/response bundle for alu_multicycle.
// Master issues operations; slave is the ALU.
interface alu_multicycle_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alufunc;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (
    output in_valid,
    output alufunc,
    output in1,
    output in2,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  result,
    input  zero
  );

  modport slave (
    input  in_valid,
    input  alufunc,
    input  in1,
    input  in2,
    input  out_ready,
    output in_ready,
    output out_valid,
    output result,
    output zero
  );
endinterface

// File: rtl/alu_multicycle.sv
// Handshaked ALU: single-cycle logic/arith ops plus
// iterative shift-add multiply and restoring divide.
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  alu_multicycle_if.slave   bus
);

  localparam logic [2:0] F_ADD  = 3'b000;
  localparam logic [2:0] F_SUB  = 3'b001;
  localparam logic [2:0] F_AND  = 3'b010;
  localparam logic [2:0] F_OR   = 3'b011;
  localparam logic [2:0] F_SLT  = 3'b100;
  localparam logic [2:0] F_MUL  = 3'b101;
  localparam logic [2:0] F_DIVU = 3'b110;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [2:0]       op;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] res_q;
  logic             zero_q;

  logic             accept;
  logic             iter_op;
  logic             last;
  logic [WIDTH-1:0] sc_res;
  logic [WIDTH-1:0] opa_nx;
  logic [WIDTH-1:0] opb_nx;
  logic [WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0] fin_res;
  logic [WIDTH-1:0] sh;
  logic             ge;

  assign bus.in_ready  = (state == S_IDLE)
                       | ((state == S_DONE) & bus.out_ready);
  assign accept        = bus.in_valid & bus.in_ready;
  assign iter_op       = bus.alufunc[2]
                       & (bus.alufunc[1] | bus.alufunc[0]);
  assign last          = (cnt == CNT_W'(1));
  assign bus.out_valid = (state == S_DONE);
  assign bus.result    = res_q;
  assign bus.zero      = zero_q;

  always_comb begin
    sc_res = '0;
    unique case (bus.alufunc)
      F_ADD:   sc_res = bus.in1 + bus.in2;
      F_SUB:   sc_res = bus.in1 - bus.in2;
      F_AND:   sc_res = bus.in1 & bus.in2;
      F_OR:    sc_res = bus.in1 | bus.in2;
      F_SLT:   sc_res = {{(WIDTH-1){1'b0}}, bus.in1 < bus.in2};
      default: sc_res = '0;
    endcase
  end

  // Divide: acc is the partial remainder, opa shifts the
  // dividend out MSB-first and collects quotient bits.
  // acc MSB set means the shifted value already exceeds opb.
  always_comb begin
    opa_nx  = opa;
    opb_nx  = opb;
    acc_nx  = acc;
    sh      = {acc[WIDTH-2:0], opa[WIDTH-1]};
    ge      = acc[WIDTH-1] | (sh >= opb);
    if (op == F_MUL) begin
      acc_nx = opb[0] ? acc + opa : acc;
      opa_nx = opa << 1;
      opb_nx = opb >> 1;
    end else begin
      acc_nx = ge ? sh - opb : sh;
      opa_nx = {opa[WIDTH-2:0], ge};
    end
    fin_res = (op == F_DIVU) ? opa_nx : acc_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      op     <= F_ADD;
      cnt    <= '0;
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
      res_q  <= '0;
      zero_q <= 1'b1;
    end else if (accept) begin
      op  <= bus.alufunc;
      opa <= bus.in1;
      opb <= bus.in2;
      acc <= '0;
      if (iter_op) begin
        state <= S_BUSY;
        cnt   <= CNT_W'(WIDTH);
      end else begin
        state  <= S_DONE;
        res_q  <= sc_res;
        zero_q <= (sc_res == '0);
      end
    end else if (state == S_BUSY) begin
      cnt <= cnt - CNT_W'(1);
      opa <= opa_nx;
      opb <= opb_nx;
      acc <= acc_nx;
      if (last) begin
        state  <= S_DONE;
        res_q  <= fin_res;
        zero_q <= (fin_res == '0);
      end
    end else if ((state == S_DONE) && bus.out_ready) begin
      state <= S_IDLE;
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle at WIDTH=32.
// Expected values are hand-computed constants.
module tb_alu_multicycle;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  alu_multicycle_if #(.WIDTH(32)) bus ();

  alu_multicycle #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(logic [2:0] f, logic [31:0] a,
                       logic [31:0] b);
    bus.in_valid = 1'b1;
    bus.alufunc  = f;
    bus.in1      = a;
    bus.in2      = b;
  endtask

  task automatic sc_op(string tag, logic [2:0] f,
                       logic [31:0] a, logic [31:0] b,
                       logic [31:0] exp);
    bus.out_ready = 1'b0;
    drive(f, a, b);
    tick();
    bus.in_valid = 1'b0;
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_res"}, bus.result, exp);
    chk({tag, "_zero"}, 32'(bus.zero), 32'(exp == 0));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk({tag, "_hold_v"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_hold_r"}, bus.result, exp);
      chk({tag, "_stall_rdy"}, 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, "_retired"}, 32'(bus.out_valid), 32'd0);
  endtask

  task automatic it_op(string tag, logic [2:0] f,
                       logic [31:0] a, logic [31:0] b,
                       logic [31:0] exp, bit poke);
    int early;
    early = 0;
    bus.out_ready = 1'b0;
    drive(f, a, b);
    tick();
    bus.in_valid = 1'b0;
    chk({tag, "_busy_rdy"}, 32'(bus.in_ready), 32'd0);
    for (int i = 1; i < 32; i++) begin
      if (poke && i == 5) drive(3'b000, 32'd7, 32'd7);
      tick();
      bus.in_valid = 1'b0;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0)
        early++;
    end
    chk({tag, "_busy"}, 32'(early), 32'd0);
    tick();
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_res"}, bus.result, exp);
    chk({tag, "_zero"}, 32'(bus.zero), 32'(exp == 0));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, "_retired"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int leak;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.alufunc   = 3'b000;
    bus.in1       = '0;
    bus.in2       = '0;
    bus.out_ready = 1'b0;
    #12;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_zero", 32'(bus.zero), 32'd1);
    chk("rst_ready", 32'(bus.in_ready), 32'd1);
    rst = 1'b0;
    tick();

    // hold a result, then reset asynchronously mid-cycle
    drive(3'b000, 32'd5, 32'd6);
    tick();
    bus.in_valid = 1'b0;
    chk("pre_rst_res", bus.result, 32'd11);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_result", bus.result, 32'd0);
    chk("arst_zero", 32'(bus.zero), 32'd1);
    chk("arst_ready", 32'(bus.in_ready), 32'd1);
    #2 rst = 1'b0;
    tick();

    sc_op("add_wrap", 3'b000, 32'hFFFF_FFFF, 32'd1, 32'h0);
    sc_op("sub", 3'b001, 32'd3, 32'd5, 32'hFFFF_FFFE);
    sc_op("and", 3'b010, 32'hF0F0_1234, 32'h0FF0_FF00,
          32'h00F0_1200);
    sc_op("or", 3'b011, 32'hF0F0_1234, 32'h0FF0_FF00,
          32'hFFF0_FF34);
    sc_op("slt_lt", 3'b100, 32'd1, 32'hFFFF_FFFF, 32'd1);
    sc_op("slt_ge", 3'b100, 32'hFFFF_FFFF, 32'd1, 32'd0);

    it_op("mul", 3'b101, 32'h0001_0003, 32'h0000_0005,
          32'h0005_000F, 1'b1);
    it_op("mul_ones", 3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          32'h0000_0001, 1'b0);
    it_op("divu", 3'b110, 32'd100, 32'd7, 32'd14, 1'b0);
    it_op("remu", 3'b111, 32'd100, 32'd7, 32'd2, 1'b0);
    it_op("divu_z", 3'b110, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0);
    it_op("remu_z", 3'b111, 32'd5, 32'd0, 32'd5, 1'b0);
    it_op("divu_1", 3'b110, 32'hFFFF_FFFF, 32'd1,
          32'hFFFF_FFFF, 1'b0);
    it_op("remu_10", 3'b111, 32'hFFFF_FFFF, 32'd10, 32'd5,
          1'b0);
    it_op("remu_0r", 3'b111, 32'd21, 32'd7, 32'd0, 1'b0);

    // DONE->DONE chaining
    bus.out_ready = 1'b1;
    drive(3'b000, 32'd2, 32'd2);
    tick();
    drive(3'b000, 32'd3, 32'd3);
    chk("b2b_v1", 32'(bus.out_valid), 32'd1);
    chk("b2b_r1", bus.result, 32'd4);
    chk("b2b_rdy", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("b2b_v2", 32'(bus.out_valid), 32'd1);
    chk("b2b_r2", bus.result, 32'd6);
    tick();
    chk("b2b_idle", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;

    // reset during MUL iteration 10
    drive(3'b101, 32'd9, 32'd9);
    tick();
    bus.in_valid = 1'b0;
    repeat (9) tick();
    #2 rst = 1'b1;
    #1;
    chk("mrst_valid", 32'(bus.out_valid), 32'd0);
    chk("mrst_ready", 32'(bus.in_ready), 32'd1);
    #2 rst = 1'b0;
    leak = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.out_valid !== 1'b0) leak++;
    end
    chk("mrst_noleak", 32'(leak), 32'd0);
    drive(3'b000, 32'd1, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("post_valid", 32'(bus.out_valid), 32'd1);
    chk("post_res", bus.result, 32'd2);
    chk("post_zero", 32'(bus.zero), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
